// File: rtl/mpu_result_streamer.sv
// rtl/mpu_result_streamer.sv - snapshot an NxN matrix and stream it row-major over valid/ready
module mpu_result_streamer #(
  parameter int N = 5,
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [N*N*W-1:0] matrix_in,
  output logic             busy,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [W-1:0]     tx_data,
  output logic [2:0]       tx_row,
  output logic [2:0]       tx_col,
  output logic             tx_last,
  output logic             done
);

  localparam int NE = N * N;
  localparam int IW = (NE > 1) ? $clog2(NE) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q, state_d;
  logic [NE*W-1:0]    snap_q, snap_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [2:0]         row_q, row_d;
  logic [2:0]         col_q, col_d;
  logic               done_q, done_d;

  logic               valid;
  logic               fire;
  logic               at_last;

  // Row/col are tracked as a counter pair alongside the flat index so no divider is needed
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    done_d  = 1'b0;

    valid   = (state_q == SEND);
    fire    = valid & tx_ready;
    at_last = (row_q == 3'(N - 1)) && (col_q == 3'(N - 1));

    case (state_q)
      IDLE: begin
        if (load) begin
          snap_d  = matrix_in;
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        // load is deliberately ignored here; the held snapshot must not change mid-stream
        if (fire) begin
          if (at_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
            idx_d   = '0;
            row_d   = '0;
            col_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
            if (col_q == 3'(N - 1)) begin
              col_d = '0;
              row_d = row_q + 3'd1;
            end else begin
              col_d = col_q + 3'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, snapshot and counter registers; reset aborts any transfer without a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      done_q  <= done_d;
    end
  end

  // Outputs decode from registered state so reset clears them immediately; idle data reads as zero
  always_comb begin
    busy     = valid;
    tx_valid = valid;
    tx_data  = valid ? snap_q[int'(idx_q)*W +: W] : '0;
    tx_row   = valid ? row_q : 3'd0;
    tx_col   = valid ? col_q : 3'd0;
    tx_last  = valid & at_last;
    done     = done_q;
  end

endmodule
